// File: rtl/datapath_ctrl_if.sv
// rtl/datapath_ctrl_if.sv - instruction handshake and datapath control bundle
// Purpose: groups the start handshake, instruction word, status and every
//          datapath control/select line of the sequencer.
// master : instruction source side (drives s/instr, observes everything else)
// slave  : sequencer side (datapath_ctrl)
interface datapath_ctrl_if;
  logic        s;
  logic [15:0] instr;
  logic        w;
  logic        illegal;
  logic [15:0] datapath_in;
  logic        vsel;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        asel;
  logic        bsel;
  logic        loads;
  logic        loadc;
  logic [2:0]  writenum;
  logic [2:0]  readnum;
  logic [1:0]  shift;
  logic [1:0]  ALUop;

  modport master (
    output s, instr,
    input  w, illegal, datapath_in, vsel, write, loada, loadb, asel, bsel,
           loads, loadc, writenum, readnum, shift, ALUop
  );

  modport slave (
    input  s, instr,
    output w, illegal, datapath_in, vsel, write, loada, loadb, asel, bsel,
           loads, loadc, writenum, readnum, shift, ALUop
  );
endinterface

// File: rtl/datapath_ctrl.sv
// rtl/datapath_ctrl.sv - multi-cycle instruction sequencer for the 16-bit datapath
// Purpose: latches an instruction on s (in WAIT), decodes it and steps the
//          register file / shifter / ALU datapath until write-back or status load.
// Ports  : clk   - rising-edge clock
//          reset - synchronous, active-high
//          bus   - datapath_ctrl_if.slave (s/instr in; w, illegal, datapath_in
//                  and all datapath controls out)
module datapath_ctrl #(
  parameter int IMM_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  datapath_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_MOVI, S_GETA, S_GETB, S_EXEC, S_CMPS, S_WB
  } state_t;

  typedef enum logic [2:0] {
    K_MOVI, K_MOVR, K_MVN, K_ADD, K_CMP, K_AND, K_ILL
  } kind_t;

  typedef struct packed {
    logic       w;
    logic       vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       asel;
    logic       bsel;
    logic       loads;
    logic       loadc;
    logic [2:0] writenum;
    logic [2:0] readnum;
    logic [1:0] shift;
    logic [1:0] aluop;
  } ctrl_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        illegal_q, illegal_d;
  ctrl_t       ctrl_q, ctrl_d;

  // Instruction class from opcode IR[15:13] and op IR[12:11].
  function automatic kind_t decode(input logic [15:0] ir);
    case ({ir[15:13], ir[12:11]})
      5'b110_10: decode = K_MOVI;
      5'b110_00: decode = K_MOVR;
      5'b101_11: decode = K_MVN;
      5'b101_00: decode = K_ADD;
      5'b101_01: decode = K_CMP;
      5'b101_10: decode = K_AND;
      default:   decode = K_ILL;
    endcase
  endfunction

  // Moore control word for a state; evaluated on the next state so the
  // outputs come straight out of flops.
  function automatic ctrl_t ctrl_for(input state_t st, input logic [15:0] ir);
    ctrl_t c;
    c = '0;
    case (st)
      S_WAIT:   c.w = 1'b1;
      S_DECODE: c = '0;
      S_MOVI: begin
        c.vsel     = 1'b1;
        c.write    = 1'b1;
        c.writenum = ir[10:8];
      end
      S_GETA: begin
        c.readnum = ir[10:8];
        c.loada   = 1'b1;
      end
      S_GETB: begin
        c.readnum = ir[2:0];
        c.loadb   = 1'b1;
      end
      S_EXEC: begin
        c.shift = ir[4:3];
        c.loadc = 1'b1;
        case (decode(ir))
          K_MOVR:  c.asel  = 1'b1;   // A operand forced to zero: result = shifted B
          K_AND:   c.aluop = 2'b10;
          K_MVN:   c.aluop = 2'b11;
          default: c.aluop = 2'b00;
        endcase
      end
      S_CMPS: begin
        c.shift = ir[4:3];
        c.aluop = 2'b01;
        c.loads = 1'b1;
      end
      S_WB: begin
        c.write    = 1'b1;
        c.writenum = ir[7:5];
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      S_WAIT: begin
        if (bus.s) begin
          ir_d      = bus.instr;
          illegal_d = 1'b0;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        case (decode(ir_q))
          K_MOVI:               state_d = S_MOVI;
          K_MOVR, K_MVN:        state_d = S_GETB;
          K_ADD, K_CMP, K_AND:  state_d = S_GETA;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_WAIT;
          end
        endcase
      end
      S_MOVI:  state_d = S_WAIT;
      S_GETA:  state_d = S_GETB;
      S_GETB:  state_d = (decode(ir_q) == K_CMP) ? S_CMPS : S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_CMPS:  state_d = S_WAIT;
      S_WB:    state_d = S_WAIT;
      default: state_d = S_WAIT;
    endcase
    ctrl_d = ctrl_for(state_d, ir_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_WAIT;
      ir_q      <= '0;
      illegal_q <= 1'b0;
      ctrl_q    <= ctrl_for(S_WAIT, '0);
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign bus.w           = ctrl_q.w;
  assign bus.illegal     = illegal_q;
  assign bus.datapath_in = {{(16-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};
  assign bus.vsel        = ctrl_q.vsel;
  assign bus.asel        = ctrl_q.asel;
  assign bus.bsel        = ctrl_q.bsel;
  assign bus.writenum    = ctrl_q.writenum;
  assign bus.readnum     = ctrl_q.readnum;
  assign bus.shift       = ctrl_q.shift;
  assign bus.ALUop       = ctrl_q.aluop;
  // Register strobes are masked while reset is high so an aborted
  // instruction cannot write or load anything in the reset cycle.
  assign bus.write       = ctrl_q.write & ~reset;
  assign bus.loada       = ctrl_q.loada & ~reset;
  assign bus.loadb       = ctrl_q.loadb & ~reset;
  assign bus.loads       = ctrl_q.loads & ~reset;
  assign bus.loadc       = ctrl_q.loadc & ~reset;

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb/tb_datapath_ctrl.sv - self-checking bench for datapath_ctrl
module tb_datapath_ctrl;

  typedef struct packed {
    logic       w;
    logic       vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       asel;
    logic       bsel;
    logic       loads;
    logic       loadc;
    logic [2:0] writenum;
    logic [2:0] readnum;
    logic [1:0] shift;
    logic [1:0] aluop;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   fails = 0;

  datapath_ctrl_if bus ();

  datapath_ctrl #(.IMM_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
    end
  endtask

  // ---------------- reference model: per-instruction cycle tables ----------------
  vec_t        seq_q[$];
  vec_t        exp_vec;
  logic [15:0] exp_ir;
  logic        exp_ill;
  logic        ill_pend;

  function automatic vec_t idle();
    vec_t v = '0;
    v.w = 1'b1;
    return v;
  endfunction

  task automatic build_seq(input logic [15:0] ir);
    vec_t z, a, b, x, wb, mi, cs;
    z = '0;
    a = '0;  a.readnum = ir[10:8]; a.loada = 1'b1;
    b = '0;  b.readnum = ir[2:0];  b.loadb = 1'b1;
    x = '0;  x.shift = ir[4:3];    x.loadc = 1'b1;
    wb = '0; wb.write = 1'b1;      wb.writenum = ir[7:5];
    mi = '0; mi.vsel = 1'b1; mi.write = 1'b1; mi.writenum = ir[10:8];
    cs = '0; cs.shift = ir[4:3]; cs.aluop = 2'b01; cs.loads = 1'b1;
    seq_q.push_back(z);
    if (ir[15:11] == 5'b11010) begin
      seq_q.push_back(mi);
    end else if (ir[15:11] == 5'b11000) begin          // MOV reg: 0 + shifted Rm
      x.asel = 1'b1;
      seq_q.push_back(b); seq_q.push_back(x); seq_q.push_back(wb);
    end else if (ir[15:11] == 5'b10111) begin          // MVN
      x.aluop = 2'b11;
      seq_q.push_back(b); seq_q.push_back(x); seq_q.push_back(wb);
    end else if (ir[15:11] == 5'b10100 || ir[15:11] == 5'b10110) begin  // ADD / AND
      x.aluop = ir[12] ? 2'b10 : 2'b00;
      seq_q.push_back(a); seq_q.push_back(b); seq_q.push_back(x); seq_q.push_back(wb);
    end else if (ir[15:11] == 5'b10101) begin          // CMP
      seq_q.push_back(a); seq_q.push_back(b); seq_q.push_back(cs);
    end else begin
      ill_pend = 1'b1;
    end
  endtask

  initial begin
    exp_vec  = idle();
    exp_ir   = '0;
    exp_ill  = 1'b0;
    ill_pend = 1'b0;
  end

  always @(posedge clk) begin
    if (reset) begin
      seq_q.delete();
      exp_vec  = idle();
      exp_ir   = '0;
      exp_ill  = 1'b0;
      ill_pend = 1'b0;
    end else begin
      if (exp_vec.w && bus.s) begin
        exp_ir  = bus.instr;
        exp_ill = 1'b0;
        build_seq(exp_ir);
      end
      if (seq_q.size() > 0) begin
        exp_vec = seq_q.pop_front();
      end else begin
        exp_vec = idle();
        if (ill_pend) begin
          exp_ill  = 1'b1;
          ill_pend = 1'b0;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  vec_t act;
  always_comb begin
    act = '0;
    act.w = bus.w;         act.vsel = bus.vsel;   act.write = bus.write;
    act.loada = bus.loada; act.loadb = bus.loadb; act.asel = bus.asel;
    act.bsel = bus.bsel;   act.loads = bus.loads; act.loadc = bus.loadc;
    act.writenum = bus.writenum; act.readnum = bus.readnum;
    act.shift = bus.shift; act.aluop = bus.ALUop;
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("strobes_in_reset",
          {27'd0, bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads}, 32'd0);
    end else begin
      chk("ctrl", {13'd0, act}, {13'd0, exp_vec});
      chk("illegal", {31'd0, bus.illegal}, {31'd0, exp_ill});
      chk("datapath_in", {16'd0, bus.datapath_in}, {16'd0, {{8{exp_ir[7]}}, exp_ir[7:0]}});
    end
  end

  // ---------------- small datapath driven by the DUT controls ----------------
  logic [15:0] regs [8];
  logic [15:0] ra, rb, rc, sh_b, a_in, alu;
  logic        z_flag;

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = '0;
    ra = '0; rb = '0; rc = '0; z_flag = 1'b0;
  end

  always_comb begin
    case (bus.shift)
      2'b00:   sh_b = rb;
      2'b01:   sh_b = rb << 1;
      2'b10:   sh_b = rb >> 1;
      default: sh_b = {rb[15], rb[15:1]};
    endcase
    a_in = bus.asel ? 16'd0 : ra;
    case (bus.ALUop)
      2'b00:   alu = a_in + sh_b;
      2'b01:   alu = a_in - sh_b;
      2'b10:   alu = a_in & sh_b;
      default: alu = ~sh_b;
    endcase
  end

  always @(posedge clk) begin
    if (bus.write) regs[bus.writenum] <= bus.vsel ? bus.datapath_in : rc;
    if (bus.loada) ra <= regs[bus.readnum];
    if (bus.loadb) rb <= regs[bus.readnum];
    if (bus.loadc) rc <= alu;
    if (bus.loads) z_flag <= (alu == 16'd0);
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_w(output int n);
    n = 1;
    forever begin
      @(negedge clk);
      if (bus.w || n >= 20) break;
      @(posedge clk);
      n++;
    end
  endtask

  task automatic issue(input logic [15:0] ins, input int exp_lat, input string name);
    int n;
    bus.s = 1'b1;
    bus.instr = ins;
    @(posedge clk);
    #1 bus.s = 1'b0;
    wait_w(n);
    chk(name, n, exp_lat);
  endtask

  initial begin
    int n;
    bus.s = 1'b0;
    bus.instr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_w", {31'd0, bus.w}, 32'd1);
    chk("reset_illegal", {31'd0, bus.illegal}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // MOV R1,#7 with literal checks on each cycle
    bus.s = 1'b1; bus.instr = 16'hD107;
    @(posedge clk);
    #1 bus.s = 1'b0;
    @(negedge clk);
    chk("movi_decode_w", {31'd0, bus.w}, 32'd0);
    @(negedge clk);
    chk("movi_write", {31'd0, bus.write}, 32'd1);
    chk("movi_vsel", {31'd0, bus.vsel}, 32'd1);
    chk("movi_writenum", {29'd0, bus.writenum}, 32'd1);
    chk("movi_imm", {16'd0, bus.datapath_in}, 32'h0007);
    @(negedge clk);
    chk("movi_w3", {31'd0, bus.w}, 32'd1);
    chk("movi_illegal", {31'd0, bus.illegal}, 32'd0);
    chk("r1_eq_7", {16'd0, regs[1]}, 32'd7);

    issue(16'hD2F0, 3, "lat_movi_neg");
    chk("r2_eq_fff0", {16'd0, regs[2]}, 32'h0000FFF0);
    issue(16'hD202, 3, "lat_movi_r2");
    issue(16'hA16A, 6, "lat_add");
    chk("r3_eq_11", {16'd0, regs[3]}, 32'd11);
    issue(16'hA901, 5, "lat_cmp");
    chk("cmp_z", {31'd0, z_flag}, 32'd1);
    issue(16'hC009, 5, "lat_movreg");
    chk("r0_eq_14", {16'd0, regs[0]}, 32'd14);
    issue(16'hB182, 6, "lat_and");
    chk("r4_eq_2", {16'd0, regs[4]}, 32'd2);
    issue(16'hB8A2, 5, "lat_mvn");
    chk("r5_eq_fffd", {16'd0, regs[5]}, 32'h0000FFFD);

    issue(16'hE000, 2, "lat_illegal");
    chk("illegal_set", {31'd0, bus.illegal}, 32'd1);
    issue(16'hD405, 3, "lat_after_illegal");
    chk("illegal_cleared", {31'd0, bus.illegal}, 32'd0);

    // s held high: back-to-back MOV R5,#1 re-issues every WAIT cycle
    bus.s = 1'b1; bus.instr = 16'hD501;
    repeat (7) @(posedge clk);
    #1 bus.s = 1'b0;
    wait_w(n);
    chk("held_s_done", n < 20, 1);
    chk("r5_eq_1", {16'd0, regs[5]}, 32'd1);

    // reset during EXEC of ADD R6,R1,R2
    bus.s = 1'b1; bus.instr = 16'hA1C2;
    @(posedge clk);
    #1 bus.s = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_abort_w", {31'd0, bus.w}, 32'd1);
    repeat (3) @(negedge clk);
    chk("r6_not_written", {16'd0, regs[6]}, 32'd0);

    // s pulse during GETA of ADD R7,R1,R2 is ignored
    bus.s = 1'b1; bus.instr = 16'hA1E2;
    @(posedge clk);
    #1 bus.s = 1'b0;
    @(posedge clk);
    #1 bus.s = 1'b1; bus.instr = 16'hE000;
    @(posedge clk);
    #1 bus.s = 1'b0; bus.instr = 16'h0000;
    wait_w(n);
    chk("geta_pulse_done", n < 20, 1);
    chk("geta_pulse_illegal", {31'd0, bus.illegal}, 32'd0);
    chk("r7_eq_9", {16'd0, regs[7]}, 32'd9);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1);
  end

endmodule
